gpu_mem_arbiter: RTL and testbench

Shares the GPU's single byte-wide Avalon-MM master (m1) between the internal render clients: voxel fetch, palette fetch and pixel writer. It arbitrates round-robin, holds the grant for the whole waitrequest stall, and tracks outstanding pipelined reads in an ID FIFO. Each m1_readdatavalid beat is routed back to the requester that issued the read. It sits between gpu_controller's fetch/write engines and the top-level m1 port.

---
 rtl/gpu_mem_arbiter_pkg.sv | 25 ++
 rtl/gpu_id_fifo.sv | 74 +++++++
 rtl/gpu_mem_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_gpu_mem_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_mem_arbiter_pkg.sv
// Shared types for the GPU memory arbiter: requester ids, ID FIFO entry type, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gpu_mem_arbiter_pkg;

    // Number of internal render clients sharing the m1 master.
    localparam int NUM_MEM_REQ = 3;

    // Requester index assignment on the arbiter ports.
    typedef enum logic [1:0] {
        REQ_VOXEL   = 2'd0,
        REQ_PALETTE = 2'd1,
        REQ_PIXEL   = 2'd2
    } mem_req_id_e;

    // Requester id as stored in the outstanding-read FIFO.
    typedef logic [$clog2(NUM_MEM_REQ)-1:0] mem_req_id_t;

    // Arbiter FSM: waiting for a request, or driving m1 for the granted client.
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_XFER = 1'b1
    } arb_state_e;

endpackage

// File: rtl/gpu_id_fifo.sv
// Synchronous FIFO of requester ids for reads that have been accepted but not yet returned.
// Latency: push visible at head on the next cycle; head is a combinational read of the oldest entry.
// Backpressure: push ignored when full, pop ignored when empty; simultaneous push/pop keeps count.
module gpu_id_fifo
    import gpu_mem_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  mem_req_id_t            push_id,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output mem_req_id_t            head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    mem_req_id_t       mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q,  count_d;
    logic              do_push;
    logic              do_pop;

    // Qualify push/pop against the current fill level and compute next pointers/count.
    always_comb begin
        do_push  = push && (count_q != (AW+1)'(DEPTH));
        do_pop   = pop  && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once count says they were written.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_id;
        end
    end

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/gpu_mem_arbiter.sv
// Round-robin share of the byte-wide m1 Avalon-MM master among voxel, palette and pixel clients.
// Latency: 1 cycle arbitration from IDLE, back-to-back re-grant in XFER; read returns routed with 0 cycles.
// Backpressure: grant held through m1_waitrequest; reads stall when MAX_PENDING are outstanding.
// Optional: define GPU_MEM_ARB_ERR_CHECK_EN to enable the sticky err_unexpected_rdv flag.
module gpu_mem_arbiter
    import gpu_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = NUM_MEM_REQ,
    parameter int MAX_PENDING = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ*32-1:0]  req_address,
    input  logic [NUM_REQ-1:0]     req_read,
    input  logic [NUM_REQ-1:0]     req_write,
    input  logic [NUM_REQ*8-1:0]   req_writedata,
    output logic [NUM_REQ-1:0]     req_waitrequest,
    output logic [NUM_REQ*8-1:0]   req_readdata,
    output logic [NUM_REQ-1:0]     req_readdatavalid,
    output logic [31:0]            m1_address,
    output logic [7:0]             m1_writedata,
    output logic                   m1_write,
    output logic                   m1_read,
    input  logic                   m1_waitrequest,
    input  logic [7:0]             m1_readdata,
    input  logic                   m1_readdatavalid,
    output logic                   err_unexpected_rdv
);

    localparam int PEND_W = $clog2(MAX_PENDING) + 1;

    arb_state_e          state_q, state_d;
    mem_req_id_t         grant_q, grant_d;
    mem_req_id_t         last_grant_q, last_grant_d;

    logic [NUM_REQ-1:0]  active;
    logic [NUM_REQ-1:0]  others;
    logic                in_xfer;
    logic                sel_read;
    logic                sel_write;
    logic                wr_eff;
    logic [31:0]         sel_addr;
    logic [7:0]          sel_wdata;
    logic                rd_blocked;
    logic                accept;

    logic                fifo_push;
    logic                fifo_full;
    logic                fifo_empty;
    mem_req_id_t         fifo_head;
    logic [PEND_W-1:0]   pending;

    // First set bit in mask strictly after index 'after', scanning upward with wrap.
    // Scanning NUM_REQ positions means 'after' itself is considered last.
    function automatic mem_req_id_t rr_pick(input mem_req_id_t after,
                                            input logic [NUM_REQ-1:0] mask);
        mem_req_id_t pick;
        logic        found;
        pick  = after;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (int'(after) + k) % NUM_REQ;
            if (!found && mask[idx]) begin
                pick  = mem_req_id_t'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign active  = req_read | req_write;
    assign in_xfer = (state_q == ARB_XFER);

    // Mux the granted requester's command onto internal select signals.
    always_comb begin
        sel_read  = 1'b0;
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        others    = active;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (mem_req_id_t'(i) == grant_q) begin
                sel_read  = req_read[i];
                sel_write = req_write[i];
                sel_addr  = req_address[i*32 +: 32];
                sel_wdata = req_writedata[i*8 +: 8];
                others[i] = 1'b0;
            end
        end
    end

`ifdef GPU_MEM_ARB_ERR_CHECK_EN
    // A read+write collision is flagged; the read takes priority and the write is dropped.
    assign wr_eff = sel_write && !sel_read;
`else
    assign wr_eff = sel_write;
`endif

    // Drive m1 from the granted client; a read is held off while the ID FIFO is full.
    always_comb begin
        rd_blocked   = in_xfer && sel_read && (pending == PEND_W'(MAX_PENDING));
        m1_read      = in_xfer && sel_read && !rd_blocked;
        m1_write     = in_xfer && wr_eff;
        m1_address   = in_xfer ? sel_addr  : 32'h0;
        m1_writedata = in_xfer ? sel_wdata : 8'h0;
        accept       = (m1_read || m1_write) && !m1_waitrequest;
    end

    // Only the granted client sees waitrequest low, and only when its command can go this cycle.
    always_comb begin
        req_waitrequest = '1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (in_xfer && (mem_req_id_t'(i) == grant_q) && !m1_waitrequest && !rd_blocked) begin
                req_waitrequest[i] = 1'b0;
            end
        end
    end

    // Arbitration FSM next state: grant from IDLE, re-grant past the winner on each accept.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ARB_IDLE: begin
                if (|active) begin
                    grant_d = rr_pick(last_grant_q, active);
                    state_d = ARB_XFER;
                end
            end
            ARB_XFER: begin
                if (accept) begin
                    last_grant_d = grant_q;
                    if (|others) begin
                        grant_d = rr_pick(grant_q, others);
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end else if (!(sel_read || sel_write)) begin
                    // Client withdrew an unstalled request; give the master up.
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // FSM and round-robin pointer registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            grant_q      <= '0;
            last_grant_q <= mem_req_id_t'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign fifo_push = accept && m1_read && !fifo_full;

    gpu_id_fifo #(
        .DEPTH (MAX_PENDING)
    ) u_id_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (fifo_push),
        .push_id (grant_q),
        .pop     (m1_readdatavalid),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head),
        .count   (pending)
    );

    // Route each returning beat to the oldest outstanding reader; stale beats strobe nobody.
    always_comb begin
        req_readdatavalid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (m1_readdatavalid && !fifo_empty && (fifo_head == mem_req_id_t'(i))) begin
                req_readdatavalid[i] = 1'b1;
            end
        end
    end

    assign req_readdata = {NUM_REQ{m1_readdata}};

`ifdef GPU_MEM_ARB_ERR_CHECK_EN
    logic err_q, err_d;

    // Sticky protocol error: a return beat with nothing outstanding, or a read+write collision.
    always_comb begin
        err_d = err_q | (m1_readdatavalid && fifo_empty) | (|(req_read & req_write));
    end

    // Error flag register, cleared only by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_unexpected_rdv = err_q;
`else
    assign err_unexpected_rdv = 1'b0;
`endif

endmodule

// File: tb/tb_gpu_mem_arbiter.sv
// Self-checking bench for gpu_mem_arbiter: arbitration order, stall hold, read tracking and stale beats.
// Latency: inputs change 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: slave stall and readdatavalid are driven directly by the scenario tasks.
module tb_gpu_mem_arbiter;

    localparam int N = 3;

`ifdef GPU_MEM_ARB_ERR_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            reset;
    logic [N*32-1:0] req_address;
    logic [N-1:0]    req_read;
    logic [N-1:0]    req_write;
    logic [N*8-1:0]  req_writedata;
    logic [N-1:0]    req_waitrequest;
    logic [N*8-1:0]  req_readdata;
    logic [N-1:0]    req_readdatavalid;
    logic [31:0]     m1_address;
    logic [7:0]      m1_writedata;
    logic            m1_write;
    logic            m1_read;
    logic            m1_waitrequest;
    logic [7:0]      m1_readdata;
    logic            m1_readdatavalid;
    logic            err_unexpected_rdv;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } beat_t;

    beat_t exp_q[$];

    always #5 clock = ~clock;

    gpu_mem_arbiter #(
        .NUM_REQ     (N),
        .MAX_PENDING (4)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .req_address        (req_address),
        .req_read           (req_read),
        .req_write          (req_write),
        .req_writedata      (req_writedata),
        .req_waitrequest    (req_waitrequest),
        .req_readdata       (req_readdata),
        .req_readdatavalid  (req_readdatavalid),
        .m1_address         (m1_address),
        .m1_writedata       (m1_writedata),
        .m1_write           (m1_write),
        .m1_read            (m1_read),
        .m1_waitrequest     (m1_waitrequest),
        .m1_readdata        (m1_readdata),
        .m1_readdatavalid   (m1_readdatavalid),
        .err_unexpected_rdv (err_unexpected_rdv)
    );

    // Scoreboard: every return strobe must match the oldest expected {requester, data}.
    always @(negedge clock) begin
        beat_t      b;
        logic [2:0] exp_s;
        if (req_readdatavalid !== 3'b000) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL rdv_unexpected: got strobe %b, expected none", req_readdatavalid);
            end else begin
                b     = exp_q.pop_front();
                exp_s = 3'b001 << b.id;
                if (req_readdatavalid !== exp_s || req_readdata[8*int'(b.id) +: 8] !== b.data) begin
                    $display("FAIL rdv_route: got strobe %b data %h, expected strobe %b data %h",
                             req_readdatavalid, req_readdata[8*int'(b.id) +: 8], exp_s, b.data);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [7:0] d);
        beat_t b;
        b.id   = id;
        b.data = d;
        exp_q.push_back(b);
    endtask

    task automatic clear_inputs();
        req_address      = '0;
        req_read         = '0;
        req_write        = '0;
        req_writedata    = '0;
        m1_waitrequest   = 1'b0;
        m1_readdata      = '0;
        m1_readdatavalid = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        @(negedge clock);
        n_checks++; if (m1_read !== 1'b0 || m1_write !== 1'b0) $display("FAIL reset_cmd: got rd %b wr %b, expected 0 0", m1_read, m1_write); else n_pass++;
        n_checks++; if (m1_address !== 32'h0 || m1_writedata !== 8'h0) $display("FAIL reset_bus: got addr %h wd %h, expected 0 0", m1_address, m1_writedata); else n_pass++;
        n_checks++; if (req_waitrequest !== 3'b111) $display("FAIL reset_wait: got %b, expected 111", req_waitrequest); else n_pass++;
        n_checks++; if (req_readdatavalid !== 3'b000) $display("FAIL reset_rdv: got %b, expected 000", req_readdatavalid); else n_pass++;
        n_checks++; if (err_unexpected_rdv !== 1'b0) $display("FAIL reset_err: got %b, expected 0", err_unexpected_rdv); else n_pass++;
        step();
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        req_read[0]          = 1'b1;
        req_address[31:0]    = 32'h100;
        @(negedge clock);
        n_checks++; if (m1_read !== 1'b0) $display("FAIL sr_arb_cycle: got m1_read %b, expected 0", m1_read); else n_pass++;
        step();
        @(negedge clock);
        n_checks++; if (m1_read !== 1'b1 || m1_address !== 32'h100) $display("FAIL sr_issue: got rd %b addr %h, expected 1 00000100", m1_read, m1_address); else n_pass++;
        n_checks++; if (req_waitrequest !== 3'b110) $display("FAIL sr_wait: got %b, expected 110", req_waitrequest); else n_pass++;
        step();
        req_read = '0;
        @(negedge clock);
        n_checks++; if (m1_read !== 1'b0) $display("FAIL sr_idle: got m1_read %b, expected 0", m1_read); else n_pass++;
        step();
        step();
        push_exp(2'd0, 8'h5A);
        m1_readdatavalid = 1'b1;
        m1_readdata      = 8'h5A;
        @(negedge clock);
        step();
        m1_readdatavalid = 1'b0;
        n_checks++; if (exp_q.size() != 0) $display("FAIL sr_return: got %0d beats missing, expected 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_rr_writes();
        int          e;
        logic [31:0] ea;
        logic [7:0]  ed;
        do_reset();
        req_address   = {32'h3000, 32'h2000, 32'h1000};
        req_writedata = {8'h33, 8'h22, 8'h11};
        req_write     = 3'b111;
        @(negedge clock);
        n_checks++; if (req_waitrequest !== 3'b111) $display("FAIL rr_idle: got %b, expected 111", req_waitrequest); else n_pass++;
        for (int k = 0; k < 6; k++) begin
            step();
            @(negedge clock);
            e  = k % 3;
            ea = 32'(32'h1000 * (e + 1));
            ed = 8'(8'h11 * (e + 1));
            n_checks++;
            if (req_waitrequest !== ~(3'b001 << e) || m1_address !== ea || m1_writedata !== ed || m1_write !== 1'b1)
                $display("FAIL rr_order%0d: got wait %b addr %h wd %h, expected wait %b addr %h wd %h",
                         k, req_waitrequest, m1_address, m1_writedata, ~(3'b001 << e), ea, ed);
            else n_pass++;
        end
        step();
        req_write = '0;
    endtask

    task automatic test_stall();
        do_reset();
        req_address   = {32'h3000, 32'h2000, 32'h1000};
        req_writedata = {8'h33, 8'h22, 8'h11};
        req_write     = 3'b111;
        @(negedge clock);
        step();
        @(negedge clock);
        n_checks++; if (req_waitrequest !== 3'b110) $display("FAIL st_first: got %b, expected 110", req_waitrequest); else n_pass++;
        step();
        m1_waitrequest = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            n_checks++;
            if (m1_address !== 32'h2000 || m1_writedata !== 8'h22 || m1_write !== 1'b1 || req_waitrequest !== 3'b111)
                $display("FAIL st_hold%0d: got addr %h wd %h wr %b wait %b, expected 00002000 22 1 111",
                         k, m1_address, m1_writedata, m1_write, req_waitrequest);
            else n_pass++;
            step();
        end
        m1_waitrequest = 1'b0;
        @(negedge clock);
        n_checks++; if (req_waitrequest !== 3'b101 || m1_address !== 32'h2000) $display("FAIL st_release: got wait %b addr %h, expected 101 00002000", req_waitrequest, m1_address); else n_pass++;
        step();
        @(negedge clock);
        n_checks++; if (req_waitrequest !== 3'b011 || m1_address !== 32'h3000) $display("FAIL st_next: got wait %b addr %h, expected 011 00003000", req_waitrequest, m1_address); else n_pass++;
        step();
        req_write = '0;
    endtask

    task automatic test_read_backpressure();
        int accepts;
        do_reset();
        req_address[95:64] = 32'h200;
        req_read[2]        = 1'b1;
        accepts            = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (m1_read === 1'b1 && req_waitrequest[2] === 1'b0) accepts++;
            step();
        end
        n_checks++; if (accepts != 4) $display("FAIL bp_accepts: got %0d, expected 4", accepts); else n_pass++;
        @(negedge clock);
        n_checks++; if (m1_read !== 1'b0 || req_waitrequest[2] !== 1'b1 || m1_address !== 32'h200) $display("FAIL bp_blocked: got rd %b wait %b addr %h, expected 0 1 00000200", m1_read, req_waitrequest[2], m1_address); else n_pass++;
        step();
        push_exp(2'd2, 8'hD0);
        m1_readdatavalid = 1'b1;
        m1_readdata      = 8'hD0;
        @(negedge clock);
        n_checks++; if (m1_read !== 1'b0) $display("FAIL bp_pop_cycle: got m1_read %b, expected 0", m1_read); else n_pass++;
        step();
        m1_readdatavalid = 1'b0;
        @(negedge clock);
        n_checks++; if (m1_read !== 1'b1 || req_waitrequest[2] !== 1'b0) $display("FAIL bp_fifth: got rd %b wait %b, expected 1 0", m1_read, req_waitrequest[2]); else n_pass++;
        step();
        req_read = '0;
        for (int k = 0; k < 4; k++) begin
            push_exp(2'd2, 8'(8'hD1 + k));
            m1_readdatavalid = 1'b1;
            m1_readdata      = 8'(8'hD1 + k);
            @(negedge clock);
            step();
        end
        m1_readdatavalid = 1'b0;
        n_checks++; if (exp_q.size() != 0) $display("FAIL bp_drain: got %0d beats missing, expected 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_interleaved();
        do_reset();
        req_address[31:0]  = 32'h400;
        req_address[63:32] = 32'h500;
        req_read           = 3'b011;
        @(negedge clock);
        step();
        @(negedge clock);
        n_checks++; if (req_waitrequest !== 3'b110 || m1_address !== 32'h400) $display("FAIL il_g0: got wait %b addr %h, expected 110 00000400", req_waitrequest, m1_address); else n_pass++;
        step();
        push_exp(2'd0, 8'hA1);
        m1_readdatavalid = 1'b1;
        m1_readdata      = 8'hA1;
        @(negedge clock);
        n_checks++; if (req_waitrequest !== 3'b101 || m1_address !== 32'h500) $display("FAIL il_g1: got wait %b addr %h, expected 101 00000500", req_waitrequest, m1_address); else n_pass++;
        step();
        req_read[1] = 1'b0;
        push_exp(2'd1, 8'hB2);
        m1_readdata = 8'hB2;
        @(negedge clock);
        n_checks++; if (req_waitrequest !== 3'b110 || m1_read !== 1'b1) $display("FAIL il_g0b: got wait %b rd %b, expected 110 1", req_waitrequest, m1_read); else n_pass++;
        step();
        req_read         = '0;
        m1_readdatavalid = 1'b0;
        @(negedge clock);
        n_checks++; if (m1_read !== 1'b0 || req_readdatavalid !== 3'b000) $display("FAIL il_gap: got rd %b rdv %b, expected 0 000", m1_read, req_readdatavalid); else n_pass++;
        step();
        push_exp(2'd0, 8'hC3);
        m1_readdatavalid = 1'b1;
        m1_readdata      = 8'hC3;
        @(negedge clock);
        step();
        n_checks++; if (exp_q.size() != 0) $display("FAIL il_order: got %0d beats missing, expected 0", exp_q.size()); else n_pass++;
        m1_readdata = 8'hC4;
        @(negedge clock);
        n_checks++; if (req_readdatavalid !== 3'b000) $display("FAIL il_pending: got %b, expected 000", req_readdatavalid); else n_pass++;
        step();
        m1_readdatavalid = 1'b0;
    endtask

    task automatic test_reset_stale();
        do_reset();
        req_address[31:0] = 32'h600;
        req_read[0]       = 1'b1;
        for (int c = 0; c < 4; c++) step();
        req_read = '0;
        #2;
        reset = 1'b1;
        @(negedge clock);
        n_checks++; if (m1_read !== 1'b0 || req_waitrequest !== 3'b111) $display("FAIL rs_clear: got rd %b wait %b, expected 0 111", m1_read, req_waitrequest); else n_pass++;
        step();
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m1_readdatavalid = 1'b1;
            m1_readdata      = 8'hEE;
            @(negedge clock);
            n_checks++; if (req_readdatavalid !== 3'b000) $display("FAIL rs_stale%0d: got %b, expected 000", k, req_readdatavalid); else n_pass++;
            step();
        end
        m1_readdatavalid = 1'b0;
        @(negedge clock);
        n_checks++; if (err_unexpected_rdv !== EXP_ERR) $display("FAIL rs_err: got %b, expected %b", err_unexpected_rdv, EXP_ERR); else n_pass++;
        step();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_rr_writes();
        test_stall();
        test_read_backpressure();
        test_interleaved();
        test_reset_stale();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
